// File: rtl/fwd_hazard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline registers and the forwarding/hazard controller.
// The pipeline side drives the master modport; the controller sits on the slave modport.
interface fwd_hazard_ctrl_if #(
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int MAX_LL     = 4,
   parameter int CNT_W      = 16
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);
   localparam int LLC_W = $clog2(MAX_LL + 1);

   logic [NUM_SRC*REG_AW-1:0]    ex_rs;
   logic [FWD_STAGES*REG_AW-1:0] stage_rd;
   logic [FWD_STAGES-1:0]        stage_wr;
   logic [NUM_SRC*SEL_W-1:0]     fwd_sel;
   logic                         id_valid;
   logic [NUM_SRC*REG_AW-1:0]    id_rs;
   logic [NUM_SRC-1:0]           id_rs_used;
   logic [REG_AW-1:0]            id_rd;
   logic                         id_is_ll;
   logic                         ex_is_load;
   logic [REG_AW-1:0]            ex_rd;
   logic                         ll_done;
   logic [REG_AW-1:0]            ll_done_rd;
   logic                         stall_id;
   logic                         flush_ex;
   logic [LLC_W-1:0]             ll_outstanding;
   logic [CNT_W-1:0]             stall_cnt;
   logic                         lu_state;

   modport master (
      output ex_rs, stage_rd, stage_wr, id_valid, id_rs, id_rs_used, id_rd,
             id_is_ll, ex_is_load, ex_rd, ll_done, ll_done_rd,
      input  fwd_sel, stall_id, flush_ex, ll_outstanding, stall_cnt, lu_state
   );

   modport slave (
      input  ex_rs, stage_rd, stage_wr, id_valid, id_rs, id_rs_used, id_rd,
             id_is_ll, ex_is_load, ex_rd, ll_done, ll_done_rd,
      output fwd_sel, stall_id, flush_ex, ll_outstanding, stall_cnt, lu_state
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select, load-use stall FSM and long-latency scoreboard for the EX/ID stages.
// No valid/ready handshake here: every input is a per-cycle pipeline level, every output a per-cycle decision.
module fwd_hazard_ctrl #(
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int LOAD_LAT   = 1,
   parameter int MAX_LL     = 4,
   parameter int CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fwd_hazard_ctrl_if.slave   bus
);
   localparam int SEL_W = $clog2(FWD_STAGES + 1);
   localparam int LLC_W = $clog2(MAX_LL + 1);
   localparam int NREG  = 1 << REG_AW;
   localparam int LC_W  = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

   typedef enum logic {
      IDLE     = 1'b0,
      LU_STALL = 1'b1
   } lu_state_e;

   lu_state_e              state_q, state_d;
   logic [LC_W-1:0]        lcnt_q, lcnt_d;
   logic [NREG-1:0]        sb_q, sb_d;
   logic [LLC_W-1:0]       ll_cnt_q, ll_cnt_d;
   logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

   logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
   logic                     lu_hit;
   logic                     sb_hit;
   logic                     ll_full;
   logic                     lu_stall;
   logic                     stall_c;
   logic                     ll_issue;
   logic                     ll_comp;

   // Scan oldest to youngest so the youngest matching stage overwrites the select.
   always_comb begin
      fwd_sel_c = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (bus.stage_wr[k] &&
                (bus.stage_rd[k*REG_AW +: REG_AW] != '0) &&
                (bus.stage_rd[k*REG_AW +: REG_AW] == bus.ex_rs[i*REG_AW +: REG_AW])) begin
               fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
            end
         end
      end
   end

   always_comb begin
      lu_hit  = 1'b0;
      sb_hit  = 1'b0;
      ll_full = 1'b0;
      if (bus.id_valid) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] != '0)) begin
               if (bus.ex_is_load && (bus.ex_rd != '0) &&
                   (bus.id_rs[i*REG_AW +: REG_AW] == bus.ex_rd)) begin
                  lu_hit = 1'b1;
               end
               if (sb_q[bus.id_rs[i*REG_AW +: REG_AW]]) begin
                  sb_hit = 1'b1;
               end
            end
         end
         if ((bus.id_rd != '0) && sb_q[bus.id_rd]) begin
            sb_hit = 1'b1;
         end
         ll_full = bus.id_is_ll && (ll_cnt_q == LLC_W'(MAX_LL));
      end
   end

   // The detecting cycle is stall cycle one; LU_STALL covers the remaining LOAD_LAT-1.
   always_comb begin
      state_d  = state_q;
      lcnt_d   = lcnt_q;
      lu_stall = 1'b0;
      case (state_q)
         IDLE: begin
            if (lu_hit) begin
               lu_stall = 1'b1;
               lcnt_d   = LC_W'(LOAD_LAT - 1);
               if (LOAD_LAT > 1) begin
                  state_d = LU_STALL;
               end
            end
         end
         LU_STALL: begin
            lu_stall = 1'b1;
            lcnt_d   = lcnt_q - LC_W'(1);
            if (lcnt_q <= LC_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            lcnt_d  = '0;
         end
      endcase
   end

   assign stall_c  = lu_stall || sb_hit || ll_full;
   assign ll_issue = bus.id_valid && bus.id_is_ll && !stall_c && (bus.id_rd != '0);
   assign ll_comp  = bus.ll_done && (bus.ll_done_rd != '0) && sb_q[bus.ll_done_rd];

   // Issue is applied after completion so a same-register pair leaves the bit set.
   always_comb begin
      sb_d     = sb_q;
      ll_cnt_d = ll_cnt_q;
      if (ll_comp) begin
         sb_d[bus.ll_done_rd] = 1'b0;
      end
      if (ll_issue) begin
         sb_d[bus.id_rd] = 1'b1;
      end
      case ({ll_issue, ll_comp})
         2'b10:   ll_cnt_d = ll_cnt_q + LLC_W'(1);
         2'b01:   ll_cnt_d = ll_cnt_q - LLC_W'(1);
         default: ll_cnt_d = ll_cnt_q;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lcnt_q      <= '0;
         sb_q        <= '0;
         ll_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lcnt_q      <= lcnt_d;
         sb_q        <= sb_d;
         ll_cnt_q    <= ll_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Combinational outputs are forced low while reset is held, not just the registers.
   assign bus.fwd_sel        = rst_n ? fwd_sel_c : '0;
   assign bus.stall_id       = rst_n && stall_c;
   assign bus.flush_ex       = rst_n && stall_c;
   assign bus.ll_outstanding = ll_cnt_q;
   assign bus.stall_cnt      = stall_cnt_q;
   assign bus.lu_state       = (state_q == LU_STALL);
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall, scoreboard, ll limit, saturation, reset.
module tb_fwd_hazard_ctrl;
   localparam int NUM_SRC    = 2;
   localparam int FWD_STAGES = 2;
   localparam int REG_AW     = 5;
   localparam int LOAD_LAT   = 2;
   localparam int MAX_LL     = 4;
   localparam int CNT_W      = 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   fwd_hazard_ctrl_if #(
      .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW),
      .MAX_LL(MAX_LL), .CNT_W(CNT_W)
   ) bus ();

   fwd_hazard_ctrl #(
      .NUM_SRC(NUM_SRC), .FWD_STAGES(FWD_STAGES), .REG_AW(REG_AW),
      .LOAD_LAT(LOAD_LAT), .MAX_LL(MAX_LL), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idle();
      bus.ex_rs      = '0;
      bus.stage_rd   = '0;
      bus.stage_wr   = '0;
      bus.id_valid   = 1'b0;
      bus.id_rs      = '0;
      bus.id_rs_used = '0;
      bus.id_rd      = '0;
      bus.id_is_ll   = 1'b0;
      bus.ex_is_load = 1'b0;
      bus.ex_rd      = '0;
      bus.ll_done    = 1'b0;
      bus.ll_done_rd = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.ex_rs      = {5'd3, 5'd3};
      bus.stage_rd   = {5'd3, 5'd3};
      bus.stage_wr   = 2'b11;
      bus.id_valid   = 1'b1;
      bus.id_rs      = {5'd0, 5'd7};
      bus.id_rs_used = 2'b01;
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd7;
      #1;
      n_tests++;
      if (bus.fwd_sel !== 4'd0) begin
         n_fail++; $display("FAIL reset_fwd_sel got %0h exp 0", bus.fwd_sel);
      end
      n_tests++;
      if (bus.stall_id !== 1'b0 || bus.flush_ex !== 1'b0) begin
         n_fail++; $display("FAIL reset_stall got %b/%b exp 0/0", bus.stall_id, bus.flush_ex);
      end
      n_tests++;
      if (bus.ll_outstanding !== 3'd0 || bus.stall_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.ll_outstanding, bus.stall_cnt);
      end
      do_reset();
   endtask

   task automatic test_forwarding();
      @(negedge clk);
      set_idle();
      bus.ex_rs    = {5'd3, 5'd3};
      bus.stage_rd = {5'd3, 5'd3};
      bus.stage_wr = 2'b11;
      #1;
      n_tests++;
      if (bus.fwd_sel !== {2'd1, 2'd1}) begin
         n_fail++; $display("FAIL fwd_youngest got %b exp 0101", bus.fwd_sel);
      end
      bus.stage_wr = 2'b10;
      #1;
      n_tests++;
      if (bus.fwd_sel !== {2'd2, 2'd2}) begin
         n_fail++; $display("FAIL fwd_stage1_only got %b exp 1010", bus.fwd_sel);
      end
      bus.ex_rs    = {5'd6, 5'd5};
      bus.stage_rd = {5'd5, 5'd6};
      bus.stage_wr = 2'b11;
      #1;
      n_tests++;
      if (bus.fwd_sel !== {2'd1, 2'd2}) begin
         n_fail++; $display("FAIL fwd_split got %b exp 0110", bus.fwd_sel);
      end
      bus.stage_wr = 2'b00;
      #1;
      n_tests++;
      if (bus.fwd_sel !== 4'd0) begin
         n_fail++; $display("FAIL fwd_no_wr got %b exp 0000", bus.fwd_sel);
      end
      bus.stage_wr = 2'b11;
      bus.stage_rd = {5'd5, 5'd0};
      bus.ex_rs    = {5'd0, 5'd0};
      #1;
      n_tests++;
      if (bus.fwd_sel !== 4'd0) begin
         n_fail++; $display("FAIL fwd_reg0 got %b exp 0000", bus.fwd_sel);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      @(negedge clk);
      bus.id_valid   = 1'b1;
      bus.id_rs      = {5'd0, 5'd7};
      bus.id_rs_used = 2'b10;
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd7;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0) begin
         n_fail++; $display("FAIL lu_unused_operand got %b exp 0", bus.stall_id);
      end
      bus.id_rs_used = 2'b01;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1 || bus.flush_ex !== 1'b1) begin
         n_fail++; $display("FAIL lu_cycle1 got %b/%b exp 1/1", bus.stall_id, bus.flush_ex);
      end
      @(negedge clk);
      bus.ex_is_load = 1'b0;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1 || bus.flush_ex !== 1'b1 || bus.lu_state !== 1'b1) begin
         n_fail++; $display("FAIL lu_cycle2 got %b/%b/%b exp 1/1/1", bus.stall_id, bus.flush_ex, bus.lu_state);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0 || bus.lu_state !== 1'b0) begin
         n_fail++; $display("FAIL lu_release got %b/%b exp 0/0", bus.stall_id, bus.lu_state);
      end
      n_tests++;
      if (bus.stall_cnt !== 4'd2) begin
         n_fail++; $display("FAIL lu_stall_cnt got %0d exp 2", bus.stall_cnt);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.stall_cnt !== 4'd2) begin
         n_fail++; $display("FAIL lu_stall_cnt_hold got %0d exp 2", bus.stall_cnt);
      end
   endtask

   task automatic test_scoreboard();
      do_reset();
      @(negedge clk);
      bus.id_valid = 1'b1;
      bus.id_is_ll = 1'b1;
      bus.id_rd    = 5'd9;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0) begin
         n_fail++; $display("FAIL sb_issue_stall got %b exp 0", bus.stall_id);
      end
      @(negedge clk);
      bus.id_is_ll   = 1'b0;
      bus.id_rd      = 5'd10;
      bus.id_rs      = {5'd9, 5'd0};
      bus.id_rs_used = 2'b10;
      bus.ll_done    = 1'b1;
      bus.ll_done_rd = 5'd12;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1 || bus.ll_outstanding !== 3'd1) begin
         n_fail++; $display("FAIL sb_raw got %b/%0d exp 1/1", bus.stall_id, bus.ll_outstanding);
      end
      @(negedge clk);
      bus.ll_done_rd = 5'd0;
      bus.id_rs_used = 2'b00;
      bus.id_rd      = 5'd9;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1 || bus.ll_outstanding !== 3'd1) begin
         n_fail++; $display("FAIL sb_waw_ignored_done got %b/%0d exp 1/1", bus.stall_id, bus.ll_outstanding);
      end
      @(negedge clk);
      bus.id_rd      = 5'd10;
      bus.id_rs_used = 2'b10;
      bus.ll_done_rd = 5'd9;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1) begin
         n_fail++; $display("FAIL sb_done_cycle got %b exp 1", bus.stall_id);
      end
      @(negedge clk);
      bus.ll_done = 1'b0;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0 || bus.ll_outstanding !== 3'd0) begin
         n_fail++; $display("FAIL sb_release got %b/%0d exp 0/0", bus.stall_id, bus.ll_outstanding);
      end
   endtask

   task automatic test_ll_full();
      do_reset();
      for (int r = 1; r <= MAX_LL; r++) begin
         @(negedge clk);
         bus.id_valid = 1'b1;
         bus.id_is_ll = 1'b1;
         bus.id_rd    = 5'(r);
      end
      @(negedge clk);
      bus.id_rd = 5'd5;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1 || bus.ll_outstanding !== 3'd4) begin
         n_fail++; $display("FAIL ll_full_held got %b/%0d exp 1/4", bus.stall_id, bus.ll_outstanding);
      end
      @(negedge clk);
      bus.ll_done    = 1'b1;
      bus.ll_done_rd = 5'd1;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b1) begin
         n_fail++; $display("FAIL ll_full_done_cycle got %b exp 1", bus.stall_id);
      end
      @(negedge clk);
      bus.ll_done = 1'b0;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0 || bus.ll_outstanding !== 3'd3) begin
         n_fail++; $display("FAIL ll_full_slot got %b/%0d exp 0/3", bus.stall_id, bus.ll_outstanding);
      end
      @(negedge clk);
      bus.id_valid = 1'b0;
      #1;
      n_tests++;
      if (bus.ll_outstanding !== 3'd4) begin
         n_fail++; $display("FAIL ll_fifth_issued got %0d exp 4", bus.ll_outstanding);
      end
   endtask

   task automatic test_sat_and_reset();
      do_reset();
      @(negedge clk);
      bus.id_valid = 1'b1;
      bus.id_is_ll = 1'b1;
      bus.id_rd    = 5'd9;
      @(negedge clk);
      bus.id_is_ll   = 1'b0;
      bus.id_rd      = 5'd0;
      bus.id_rs      = {5'd9, 5'd0};
      bus.id_rs_used = 2'b10;
      repeat (20) @(negedge clk);
      #1;
      n_tests++;
      if (bus.stall_cnt !== 4'd15 || bus.stall_id !== 1'b1) begin
         n_fail++; $display("FAIL sat_stall_cnt got %0d/%b exp 15/1", bus.stall_cnt, bus.stall_id);
      end
      @(negedge clk);
      bus.id_rs      = {5'd0, 5'd7};
      bus.id_rs_used = 2'b01;
      bus.ex_is_load = 1'b1;
      bus.ex_rd      = 5'd7;
      bus.ex_rs      = {5'd4, 5'd4};
      bus.stage_rd   = {5'd4, 5'd4};
      bus.stage_wr   = 2'b01;
      @(negedge clk);
      bus.ex_is_load = 1'b0;
      #1;
      n_tests++;
      if (bus.lu_state !== 1'b1 || bus.fwd_sel !== {2'd1, 2'd1}) begin
         n_fail++; $display("FAIL midstall_pre got %b/%b exp 1/0101", bus.lu_state, bus.fwd_sel);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.fwd_sel !== 4'd0 || bus.stall_id !== 1'b0 || bus.flush_ex !== 1'b0) begin
         n_fail++; $display("FAIL midstall_reset_comb got %b/%b/%b exp 0/0/0", bus.fwd_sel, bus.stall_id, bus.flush_ex);
      end
      n_tests++;
      if (bus.ll_outstanding !== 3'd0 || bus.stall_cnt !== 4'd0 || bus.lu_state !== 1'b0) begin
         n_fail++; $display("FAIL midstall_reset_regs got %0d/%0d/%b exp 0/0/0", bus.ll_outstanding, bus.stall_cnt, bus.lu_state);
      end
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      bus.id_valid   = 1'b1;
      bus.id_rs      = {5'd9, 5'd0};
      bus.id_rs_used = 2'b10;
      #1;
      n_tests++;
      if (bus.stall_id !== 1'b0) begin
         n_fail++; $display("FAIL sb_lost_after_reset got %b exp 0", bus.stall_id);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      set_idle();
      test_reset();
      test_forwarding();
      test_load_use();
      test_scoreboard();
      test_ll_full();
      test_sat_and_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
